// File: rtl/kd_tree_node_loader.sv
// kd_tree_node_loader
//   Writer side of the KD-tree internal-node config interface. Takes a stream
//   of split words from the upstream deserializer and programs the internal
//   nodes one per accepted word, in breadth-first order (node 0 is the root,
//   the children of node i are 2i+1 and 2i+2). Each write drives the shared
//   wdata bus together with a single one-hot wen strobe.
//
//   Optional feature macro: KD_LOADER_CHECK_EN
//     When defined, accepted words whose split dim index is >= NUM_DIMS are
//     consumed without a write strobe, and the sticky err flag is raised.
//     When undefined, every accepted word is written and err stays 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   1-cycle pulse: begin loading from node 0
//   in_valid   in   upstream word valid
//   in_ready   out  loader can accept a word this cycle
//   in_data    in   upstream config word {split value[21:11], split dim[10:0]}
//   wen        out  one-hot per-node write strobe
//   wdata      out  shared config bus to the internal nodes
//   node_addr  out  index of the next node to be written
//   busy       out  high while loading
//   done       out  high once the tree is fully programmed
//   err        out  sticky bad-dimension flag
module kd_tree_node_loader #(
  parameter int unsigned STORAGE_WIDTH = 22,
  parameter int unsigned NUM_NODES     = 31,
  parameter int unsigned NUM_DIMS      = 5,
  parameter int unsigned ADDR_WIDTH    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [STORAGE_WIDTH-1:0] in_data,
  output logic [NUM_NODES-1:0]     wen,
  output logic [STORAGE_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0]    node_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned DIM_WIDTH = 11;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);

`ifdef KD_LOADER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic accept_c;
  logic bad_dim_c;

  // in_ready is only ever high in LOAD, so this is the handshake itself
  assign accept_c  = in_valid && in_ready;
  assign bad_dim_c = CHECK_EN && (in_data[DIM_WIDTH-1:0] >= DIM_WIDTH'(NUM_DIMS));

  // Load sequencer; all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wen       <= '0;
      wdata     <= '0;
      node_addr <= '0;
    end else begin
      // Strobe lasts exactly one cycle after each accept
      wen <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            node_addr <= '0;
          end
        end
        LOAD: begin
          // start is deliberately ignored here: no mid-load restart
          if (accept_c) begin
            wdata <= in_data;
            if (bad_dim_c) begin
              err <= 1'b1;
            end else begin
              wen <= NUM_NODES'(1) << node_addr;
            end
            // node_addr parks on the last node instead of wrapping
            if (node_addr == LAST_ADDR) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              node_addr <= node_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kd_tree_node_loader.sv
// Testbench for kd_tree_node_loader: randomized word streams checked against
// a load-count reference model.
module tb_kd_tree_node_loader;

  localparam int unsigned SW = 22;
  localparam int unsigned NN = 31;
  localparam int unsigned ND = 5;
  localparam int unsigned AW = 5;

`ifdef KD_LOADER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_data = '0;
  logic [NN-1:0] wen;
  logic [SW-1:0] wdata;
  logic [AW-1:0] node_addr;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 loading, 2 finished
  int            m_phase = 0;
  int            m_count = 0;
  logic [NN-1:0] m_wen   = '0;
  logic [SW-1:0] m_wdata = '0;
  logic          m_err   = 1'b0;

  kd_tree_node_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wen       (wen),
    .wdata     (wdata),
    .node_addr (node_addr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] rand_word();
    return {11'($urandom), 11'($urandom_range(0, ND - 1))};
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    return (m_count > int'(NN - 1)) ? AW'(NN - 1) : AW'(m_count);
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit
  task automatic step(input logic r, input logic s, input logic v, input logic [SW-1:0] d);
    logic acc;
    logic bad;
    rst = r; start = s; in_valid = v; in_data = d;
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_count = 0; m_wen = '0; m_wdata = '0; m_err = 1'b0;
    end else begin
      acc   = (m_phase == 1) && v;
      bad   = CHECK_EN && (int'(d[10:0]) >= int'(ND));
      m_wen = '0;
      if (acc) begin
        if (!bad) m_wen[m_count] = 1'b1;
        m_wdata = d;
        if (bad) m_err = 1'b1;
        m_count++;
        if (m_count == int'(NN)) m_phase = 2;
      end else if (s && m_phase != 1) begin
        m_phase = 1; m_count = 0; m_err = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, rand_word());
    step(1'b1, 1'b1, 1'b1, rand_word());
    n_checks++; if (wen !== '0)       begin n_fail++; $display("FAIL reset_wen got=%h exp=0", wen); end
    n_checks++; if (wdata !== '0)     begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_checks++; if (node_addr !== '0) begin n_fail++; $display("FAIL reset_node_addr got=%0d exp=0", node_addr); end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, 1'b0, '0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_start got=%b exp=1", in_ready); end
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL b2b_busy_after_start got=%b exp=1", busy); end
    // Words plus a few extra valid cycles that must not be consumed
    for (int i = 0; i < int'(NN) + 3; i++) begin
      step(1'b0, 1'b0, 1'b1, rand_word());
      n_checks++; if (wen !== m_wen)           begin n_fail++; $display("FAIL b2b_wen i=%0d got=%h exp=%h", i, wen, m_wen); end
      n_checks++; if (wdata !== m_wdata)       begin n_fail++; $display("FAIL b2b_wdata i=%0d got=%h exp=%h", i, wdata, m_wdata); end
      n_checks++; if (node_addr !== exp_addr()) begin n_fail++; $display("FAIL b2b_node_addr i=%0d got=%0d exp=%0d", i, node_addr, exp_addr()); end
      n_checks++; if (in_ready !== (m_phase == 1)) begin n_fail++; $display("FAIL b2b_in_ready i=%0d got=%b exp=%b", i, in_ready, m_phase == 1); end
      n_checks++; if (done !== (m_phase == 2)) begin n_fail++; $display("FAIL b2b_done i=%0d got=%b exp=%b", i, done, m_phase == 2); end
    end
  endtask

  task automatic test_valid_gaps();
    int            strobes = 0;
    logic [NN-1:0] seen = '0;
    step(1'b0, 1'b1, 1'b0, '0);
    for (int c = 0; c < 200 && m_phase != 2; c++) begin
      step(1'b0, 1'b0, (c % 2) == 0, rand_word());
      n_checks++; if (wen !== m_wen)            begin n_fail++; $display("FAIL gaps_wen c=%0d got=%h exp=%h", c, wen, m_wen); end
      n_checks++; if (node_addr !== exp_addr()) begin n_fail++; $display("FAIL gaps_node_addr c=%0d got=%0d exp=%0d", c, node_addr, exp_addr()); end
      n_checks++; if (busy !== (m_phase == 1))  begin n_fail++; $display("FAIL gaps_busy c=%0d got=%b exp=%b", c, busy, m_phase == 1); end
      if (wen != '0) strobes++;
      seen |= wen;
    end
    n_checks++; if (m_phase != 2)    begin n_fail++; $display("FAIL gaps_timeout model phase=%0d exp=2", m_phase); end
    n_checks++; if (strobes != int'(NN)) begin n_fail++; $display("FAIL gaps_strobe_count got=%0d exp=%0d", strobes, NN); end
    n_checks++; if (seen !== {NN{1'b1}}) begin n_fail++; $display("FAIL gaps_nodes_covered got=%h exp=all", seen); end
    n_checks++; if (done !== 1'b1)   begin n_fail++; $display("FAIL gaps_done got=%b exp=1", done); end
  endtask

  task automatic test_root_word();
    logic [SW-1:0] root;
    root = 22'b0000000001000000000001;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    // start and valid together in IDLE: word must not be taken
    step(1'b0, 1'b1, 1'b1, root);
    n_checks++; if (wen !== '0)        begin n_fail++; $display("FAIL root_same_cycle_wen got=%h exp=0", wen); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL root_ready got=%b exp=1", in_ready); end
    step(1'b0, 1'b0, 1'b1, root);
    n_checks++; if (wen !== NN'(1))    begin n_fail++; $display("FAIL root_wen got=%h exp=%h", wen, NN'(1)); end
    n_checks++; if (wdata !== root)    begin n_fail++; $display("FAIL root_wdata got=%h exp=%h", wdata, root); end
    n_checks++; if (wen !== m_wen)     begin n_fail++; $display("FAIL root_model_wen got=%h exp=%h", wen, m_wen); end
    // start while loading is ignored
    step(1'b0, 1'b1, 1'b1, rand_word());
    n_checks++; if (node_addr !== exp_addr()) begin n_fail++; $display("FAIL root_start_ignored_addr got=%0d exp=%0d", node_addr, exp_addr()); end
    n_checks++; if (wen !== m_wen)     begin n_fail++; $display("FAIL root_start_ignored_wen got=%h exp=%h", wen, m_wen); end
  endtask

  task automatic test_midload_reset();
    logic [SW-1:0] w;
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, rand_word());
    n_checks++; if (node_addr !== exp_addr()) begin n_fail++; $display("FAIL mid_addr_before got=%0d exp=%0d", node_addr, exp_addr()); end
    step(1'b1, 1'b0, 1'b1, rand_word());
    n_checks++; if (wen !== '0)        begin n_fail++; $display("FAIL mid_reset_wen got=%h exp=0", wen); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=0", in_ready); end
    n_checks++; if (node_addr !== '0)  begin n_fail++; $display("FAIL mid_reset_addr got=%0d exp=0", node_addr); end
    step(1'b0, 1'b1, 1'b0, '0);
    w = rand_word();
    step(1'b0, 1'b0, 1'b1, w);
    n_checks++; if (wen !== m_wen)     begin n_fail++; $display("FAIL mid_reload_wen got=%h exp=%h", wen, m_wen); end
    n_checks++; if (wdata !== w)       begin n_fail++; $display("FAIL mid_reload_wdata got=%h exp=%h", wdata, w); end
  endtask

  task automatic test_dim_check();
    logic [SW-1:0] d;
    logic [NN-1:0] seen = '0;
    logic [NN-1:0] m_seen = '0;
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < int'(NN); i++) begin
      d = (i == 3) ? {11'd5, 11'd7} : rand_word();
      step(1'b0, 1'b0, 1'b1, d);
      seen |= wen;
      m_seen |= m_wen;
      n_checks++; if (wen !== m_wen) begin n_fail++; $display("FAIL dim_wen i=%0d got=%h exp=%h", i, wen, m_wen); end
      n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL dim_err i=%0d got=%b exp=%b", i, err, m_err); end
      n_checks++; if (node_addr !== exp_addr()) begin n_fail++; $display("FAIL dim_addr i=%0d got=%0d exp=%0d", i, node_addr, exp_addr()); end
    end
    n_checks++; if (seen !== m_seen) begin n_fail++; $display("FAIL dim_nodes_written got=%h exp=%h", seen, m_seen); end
    n_checks++; if (done !== 1'b1)   begin n_fail++; $display("FAIL dim_done got=%b exp=1", done); end
    step(1'b0, 1'b0, 1'b0, '0);
    n_checks++; if (err !== m_err)   begin n_fail++; $display("FAIL dim_err_held got=%b exp=%b", err, m_err); end
    step(1'b0, 1'b1, 1'b0, '0);
    n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL dim_err_cleared got=%b exp=0", err); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL dim_done_cleared got=%b exp=0", done); end
    n_checks++; if (node_addr !== '0) begin n_fail++; $display("FAIL dim_addr_restart got=%0d exp=0", node_addr); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_valid_gaps();
    test_root_word();
    test_midload_reset();
    test_dim_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
